// File: rtl/smart_home_spi_pkg.sv
// Shared constants and state encoding for the smart-home SPI master.
// The humidity slave returns a 40-bit word at the top of every 88-bit frame.
package smart_home_spi_pkg;

  localparam int FRAME_BITS  = 88;
  localparam int HYM_BITS    = 40;
  localparam int DEF_CLK_DIV = 8;
  localparam int DEF_CS_GAP  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_sck_divider.sv
// SCK phase counter: one full SCK period is 2*CLK_DIV clk cycles, with a rise
// strobe ending the low half and a fall strobe ending the high half.
module spi_sck_divider #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int PW = $clog2(2 * CLK_DIV);

  logic [PW-1:0] phase;

  assign rise = en && (phase == PW'(CLK_DIV - 1));
  assign fall = en && (phase == PW'(2 * CLK_DIV - 1));

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || !en || fall) phase <= '0;
    else                    phase <= phase + 1'b1;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one FRAME_BITS frame per accepted start, with SSEL setup,
// hold and idle gap of CS_GAP clk cycles around the SCK burst.
module spi_master #(
  parameter int FRAME_BITS = smart_home_spi_pkg::FRAME_BITS,
  parameter int CLK_DIV    = smart_home_spi_pkg::DEF_CLK_DIV,
  parameter int CS_GAP     = smart_home_spi_pkg::DEF_CS_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SSEL
);

  import smart_home_spi_pkg::*;

  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam int GCW = $clog2(CS_GAP + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(CS_GAP - 1);

  spi_state_t            state;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [BCW-1:0]        bit_cnt;
  logic [GCW-1:0]        gap_cnt;
  logic                  rise;
  logic                  fall;

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   ((state == SCK_LO) || (state == SCK_HI)),
    .rise (rise),
    .fall (fall)
  );

  // NOTE: every register, including the wide shift registers and rx_data, is
  // cleared by reset so an aborted frame leaves nothing visible behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      SSEL     <= 1'b1;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          tx_shift <= tx_data;
          MOSI     <= tx_data[FRAME_BITS-1];
          rx_shift <= '0;
          bit_cnt  <= '0;
          gap_cnt  <= '0;
          SSEL     <= 1'b0;
          busy     <= 1'b1;
          state    <= SETUP;
        end
        SETUP: if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
          state   <= SCK_LO;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        // MISO is taken on the same edge that raises SCK, before the slave
        // can react to that edge and shift its next bit out.
        SCK_LO: if (rise) begin
          SCK      <= 1'b1;
          rx_shift <= {rx_shift[FRAME_BITS-2:0], MISO};
          state    <= SCK_HI;
        end
        SCK_HI: if (fall) begin
          SCK      <= 1'b0;
          bit_cnt  <= bit_cnt + 1'b1;
          tx_shift <= tx_shift << 1;
          if (bit_cnt == LAST_BIT) begin
            MOSI  <= 1'b0;
            state <= HOLD;
          end else begin
            MOSI  <= tx_shift[FRAME_BITS-2];
            state <= SCK_LO;
          end
        end
        HOLD: if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
          SSEL    <= 1'b1;
          rx_data <= rx_shift;
          done    <= 1'b1;
          state   <= GAP;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
